fetch_steer_ctrl: RTL and testbench

FETCH_STEER_CTRL -- requirements
Module: fetch_steer_ctrl

---
 rtl/fetch_steer_ctrl.sv | 117 +++++++++++
 tb/tb_fetch_steer_ctrl.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_steer_ctrl.sv
// fetch_steer_ctrl: next-PC steering and fetch freeze/flush control.
// Priority: commit redirect > decode JAL > backend stall > BTB hit > PC+4.
module fetch_steer_ctrl #(
  parameter int              WIDTH        = 31,
  parameter logic [WIDTH:0]  RESET_VECTOR = '0,
  parameter int              FLUSH_CYCLES = 2
) (
  input  logic             clk,
  input  logic             globalResetN,
  input  logic             mispredict,
  input  logic             misdirect,
  input  logic             commitReset,
  input  logic [WIDTH:0]   commitTarget,
  input  logic             decodeJAL,
  input  logic [WIDTH:0]   jalTarget,
  input  logic             predictorHit,
  input  logic [WIDTH:0]   predictedPC,
  input  logic             backendStall,
  output logic [WIDTH:0]   nextPC,
  output logic             freeze,
  output logic             flushDecode,
  output logic             redirect,
  output logic [15:0]      redirectCount
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    STALL,
    RECOVER
  } state_t;

  localparam logic [2:0] FC = 3'(FLUSH_CYCLES);

  state_t         state;
  logic [2:0]     rcnt;
  logic           boot_done;
  logic           commit;
  logic [WIDTH:0] pc_inc;

  assign commit = mispredict | misdirect | commitReset;
  assign pc_inc = nextPC + {{(WIDTH-2){1'b0}}, 3'd4};

  always_ff @(posedge clk or negedge globalResetN) begin
    if (!globalResetN) begin
      state         <= BOOT;
      nextPC        <= RESET_VECTOR;
      freeze        <= 1'b1;
      flushDecode   <= 1'b0;
      redirect      <= 1'b0;
      rcnt          <= '0;
      boot_done     <= 1'b0;
      redirectCount <= '0;
    end else begin
      flushDecode <= 1'b0;
      if (state == BOOT) begin
        boot_done <= 1'b1;
        if (boot_done) begin
          state  <= RUN;
          freeze <= 1'b0;
        end
      end else if (commit) begin
        nextPC      <= commitTarget;
        state       <= RECOVER;
        rcnt        <= FC;
        flushDecode <= 1'b1;
        freeze      <= 1'b1;
        redirect    <= 1'b0;
        if (redirectCount != 16'hFFFF)
          redirectCount <= redirectCount + 16'd1;
      end else begin
        case (state)
          RECOVER: begin
            if (rcnt <= 3'd1) begin
              state  <= backendStall ? STALL : RUN;
              freeze <= backendStall;
              rcnt   <= '0;
            end else begin
              rcnt <= rcnt - 3'd1;
            end
          end
          STALL: begin
            if (decodeJAL) begin
              nextPC      <= jalTarget;
              flushDecode <= 1'b1;
              redirect    <= 1'b0;
              state       <= RUN;
              freeze      <= 1'b0;
            end else if (!backendStall) begin
              state  <= RUN;
              freeze <= 1'b0;
            end
          end
          default: begin
            if (decodeJAL) begin
              nextPC      <= jalTarget;
              flushDecode <= 1'b1;
              redirect    <= 1'b0;
              state       <= backendStall ? STALL : RUN;
              freeze      <= backendStall;
            end else if (backendStall) begin
              state  <= STALL;
              freeze <= 1'b1;
            end else if (predictorHit) begin
              nextPC   <= predictedPC;
              redirect <= 1'b1;
            end else begin
              nextPC   <= pc_inc;
              redirect <= 1'b0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_steer_ctrl.sv
// Scoreboarded random + directed bench for fetch_steer_ctrl.
// Stimulus pushes model expectations; a monitor pops after each edge.
module tb_fetch_steer_ctrl;

  localparam int FC = 2;

  logic        clk = 1'b0;
  logic        globalResetN = 1'b0;
  logic        mispredict = 0, misdirect = 0, commitReset = 0;
  logic [31:0] commitTarget = 0, jalTarget = 0, predictedPC = 0;
  logic        decodeJAL = 0, predictorHit = 0, backendStall = 0;
  logic [31:0] nextPC;
  logic        freeze, flushDecode, redirect;
  logic [15:0] redirectCount;

  fetch_steer_ctrl #(.WIDTH(31), .RESET_VECTOR(32'h0), .FLUSH_CYCLES(FC)) dut (
    .clk(clk), .globalResetN(globalResetN),
    .mispredict(mispredict), .misdirect(misdirect),
    .commitReset(commitReset), .commitTarget(commitTarget),
    .decodeJAL(decodeJAL), .jalTarget(jalTarget),
    .predictorHit(predictorHit), .predictedPC(predictedPC),
    .backendStall(backendStall), .nextPC(nextPC), .freeze(freeze),
    .flushDecode(flushDecode), .redirect(redirect),
    .redirectCount(redirectCount)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        fr;
    logic        fl;
    logic        rd;
    logic [15:0] rc;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  // reference model: cycles left in boot / freeze window, plus stall flag
  int          m_boot, m_rec;
  bit          m_stall;
  logic [31:0] m_pc;
  bit          m_fr, m_fl, m_rd;
  int          m_cnt;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic model_reset();
    m_boot = 2; m_rec = 0; m_stall = 0; m_pc = 32'h0;
    m_fr = 1; m_fl = 0; m_rd = 0; m_cnt = 0;
  endtask

  task automatic model_step(input bit cm, input bit jal, input bit hit,
                            input bit st, input logic [31:0] ct,
                            input logic [31:0] jt, input logic [31:0] pp);
    m_fl = 0;
    if (m_boot > 0) begin
      m_boot--;
      if (m_boot == 0) m_fr = 0;
    end else if (cm) begin
      m_pc = ct; m_rec = FC; m_fl = 1; m_fr = 1; m_rd = 0; m_stall = 0;
      if (m_cnt < 65535) m_cnt++;
    end else if (m_rec > 0) begin
      m_rec--;
      if (m_rec == 0) begin m_stall = st; m_fr = st; end
    end else if (m_stall) begin
      if (jal) begin
        m_pc = jt; m_fl = 1; m_rd = 0; m_stall = 0; m_fr = 0;
      end else if (!st) begin
        m_stall = 0; m_fr = 0;
      end
    end else if (jal) begin
      m_pc = jt; m_fl = 1; m_rd = 0; m_stall = st; m_fr = st;
    end else if (st) begin
      m_stall = 1; m_fr = 1;
    end else if (hit) begin
      m_pc = pp; m_rd = 1;
    end else begin
      m_pc = m_pc + 32'd4; m_rd = 0;
    end
  endtask

  // called at a negedge; returns at the following negedge
  task automatic step(input int cm, input bit jal, input bit hit,
                      input bit st, input logic [31:0] ct,
                      input logic [31:0] jt, input logic [31:0] pp);
    exp_t e;
    mispredict = (cm == 1); misdirect = (cm == 2); commitReset = (cm == 3);
    decodeJAL = jal; predictorHit = hit; backendStall = st;
    commitTarget = ct; jalTarget = jt; predictedPC = pp;
    model_step(cm != 0, jal, hit, st, ct, jt, pp);
    e.pc = m_pc; e.fr = m_fr; e.fl = m_fl; e.rd = m_rd; e.rc = 16'(m_cnt);
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    globalResetN = 0;
    mispredict = 0; misdirect = 0; commitReset = 0;
    decodeJAL = 0; predictorHit = 0; backendStall = 0;
    #1;
    chk("rst_nextPC", nextPC, 32'h0);
    chk("rst_freeze", 32'(freeze), 32'd1);
    chk("rst_flush", 32'(flushDecode), 32'd0);
    chk("rst_redirect", 32'(redirect), 32'd0);
    chk("rst_count", 32'(redirectCount), 32'd0);
    q.delete();
    model_reset();
    @(negedge clk);
    globalResetN = 1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_nextPC", nextPC, e.pc);
        chk("sb_freeze", 32'(freeze), 32'(e.fr));
        chk("sb_flush", 32'(flushDecode), 32'(e.fl));
        chk("sb_redirect", 32'(redirect), 32'(e.rd));
        chk("sb_count", 32'(redirectCount), 32'(e.rc));
      end
    end
  end

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, required finish");
    $fatal(1);
  end

  initial begin : stim
    @(negedge clk);
    do_reset();
    // boot: inputs ignored, then 0,4,8,12
    step(1, 1, 1, 0, 32'h900, 32'h904, 32'h908);
    chk("boot_freeze", 32'(freeze), 32'd1);
    chk("boot_pc", nextPC, 32'h0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("run_pc0", nextPC, 32'h0);
    chk("run_freeze", 32'(freeze), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0); chk("run_pc4", nextPC, 32'h4);
    step(0, 0, 0, 0, 0, 0, 0); chk("run_pc8", nextPC, 32'h8);
    step(0, 0, 0, 0, 0, 0, 0); chk("run_pc12", nextPC, 32'hC);
    // predictor hit
    step(0, 1, 0, 0, 0, 32'h40, 0);
    chk("jal_flush", 32'(flushDecode), 32'd1);
    step(0, 0, 1, 0, 0, 0, 32'h100);
    chk("hit_pc", nextPC, 32'h100);
    chk("hit_redirect", 32'(redirect), 32'd1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("hit_next", nextPC, 32'h104);
    chk("hit_redir0", 32'(redirect), 32'd0);
    // commit mispredict
    step(1, 0, 0, 0, 32'h200, 0, 0);
    chk("cm_pc", nextPC, 32'h200);
    chk("cm_flush", 32'(flushDecode), 32'd1);
    chk("cm_count", 32'(redirectCount), 32'd1);
    step(0, 1, 1, 0, 0, 32'h700, 32'h800);
    chk("rec_flush", 32'(flushDecode), 32'd0);
    chk("rec_freeze", 32'(freeze), 32'd1);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rec_exit", 32'(freeze), 32'd0);
    chk("rec_pc", nextPC, 32'h200);
    step(0, 0, 0, 0, 0, 0, 0); chk("rec_after", nextPC, 32'h204);
    // commit beats JAL
    step(1, 1, 0, 0, 32'h400, 32'h300, 0);
    chk("cmjal_pc", nextPC, 32'h400);
    idle(4);
    // backend stall
    step(0, 1, 0, 0, 0, 32'h80, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, 0, 0, 32'h500);
      chk("stall_freeze", 32'(freeze), 32'd1);
      chk("stall_pc", nextPC, 32'h80);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    chk("unstall_freeze", 32'(freeze), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0); chk("unstall_pc", nextPC, 32'h84);
    // JAL with stall, then PC wrap
    step(0, 1, 0, 1, 0, 32'hFFFF_FFFC, 0);
    chk("jalst_freeze", 32'(freeze), 32'd1);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 0); chk("wrap_pc", nextPC, 32'h0);
    // async reset during recovery
    step(2, 0, 0, 0, 32'h500, 0, 0);
    do_reset();
    idle(3);
    // random
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        step(($urandom_range(0, 11) == 0) ? int'($urandom_range(1, 3)) : 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
             $urandom_range(0, 3) == 0,
             $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
             $urandom & 32'hFFFF_FFFC);
      end
    end
    // redirect counter saturation
    do_reset();
    for (int i = 0; i < 65540; i++) step(3, 0, 0, 0, 32'h1000, 0, 0);
    chk("sat_count", 32'(redirectCount), 32'hFFFF);
    step(1, 0, 0, 0, 32'h2000, 0, 0);
    chk("sat_hold", 32'(redirectCount), 32'hFFFF);
    idle(4);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
